// File: rtl/decode_ctrl_stage_if.sv
// Fetch-side and execute-side channels of the decode/control stage.
// A word moves on a clock edge where valid && ready; a producer keeps valid and its payload stable until then.
interface decode_ctrl_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_is_branch;
    logic            out_is_jump;
    logic            out_mem_to_reg;
    logic            out_alu_from_imm;
    logic            out_alu_from_pc;
    logic            out_reg_write;
    logic            out_csr_source;
    logic            out_is_mret;
    logic [1:0]      out_reg_data;
    logic [3:0]      out_inst_type;
    logic [4:0]      out_alu_op;
    logic [1:0]      out_csr_op;
    logic            out_exc_request;
    logic [31:0]     out_exc_cause;

    // master: fetch/execute environment, slave: the decode stage
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_is_branch, out_is_jump,
               out_mem_to_reg, out_alu_from_imm, out_alu_from_pc, out_reg_write,
               out_csr_source, out_is_mret, out_reg_data, out_inst_type, out_alu_op,
               out_csr_op, out_exc_request, out_exc_cause
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_is_branch, out_is_jump,
               out_mem_to_reg, out_alu_from_imm, out_alu_from_pc, out_reg_write,
               out_csr_source, out_is_mret, out_reg_data, out_inst_type, out_alu_op,
               out_csr_op, out_exc_request, out_exc_cause
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32I(+M) decode/control stage: one registered control word per accepted instruction,
// with WFI sleep and FENCE drain states that stall intake.
module decode_ctrl_stage #(
    parameter int XLEN        = 32,
    parameter int SUPPORT_M   = 0,
    parameter int SUPPORT_CSR = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 irq_pending,
    input  logic                 lsu_idle,
    decode_ctrl_stage_if.slave   bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WFI   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic        is_branch;
        logic        is_jump;
        logic        mem_to_reg;
        logic        alu_from_imm;
        logic        alu_from_pc;
        logic        reg_write;
        logic        csr_source;
        logic        is_mret;
        logic [1:0]  reg_data;
        logic [3:0]  inst_type;
        logic [4:0]  alu_op;
        logic [1:0]  csr_op;
        logic        exc_request;
        logic [31:0] exc_cause;
        logic        is_wfi;
        logic        is_fence;
    } ctrl_t;

    state_t state;
    logic   run_en;
    logic   accept;
    logic   illegal;
    ctrl_t  dec;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign f3     = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign f7     = bus.in_instr[31:25];

    // run_en keeps in_ready low until the first clock after reset release
    assign bus.in_ready = run_en && (state == ST_RUN) && (!bus.out_valid || bus.out_ready) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign dbg_state    = state;

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        case (opcode)
            7'b0110111: begin
                dec.reg_write    = 1'b1;
                dec.reg_data     = 2'd3;
                dec.alu_from_imm = 1'b1;
            end
            7'b0010111: begin
                dec.reg_write    = 1'b1;
                dec.alu_from_pc  = 1'b1;
                dec.alu_from_imm = 1'b1;
            end
            7'b1101111: begin
                dec.is_jump      = 1'b1;
                dec.reg_write    = 1'b1;
                dec.reg_data     = 2'd1;
                dec.alu_from_pc  = 1'b1;
                dec.alu_from_imm = 1'b1;
            end
            7'b1100111: begin
                dec.is_jump      = 1'b1;
                dec.reg_write    = 1'b1;
                dec.reg_data     = 2'd1;
                dec.alu_from_imm = 1'b1;
            end
            7'b1100011: begin
                dec.is_branch = 1'b1;
                case (f3)
                    3'b000:  dec.alu_op = 5'd10;
                    3'b001:  dec.alu_op = 5'd11;
                    3'b100:  dec.alu_op = 5'd3;
                    3'b101:  dec.alu_op = 5'd12;
                    3'b110:  dec.alu_op = 5'd4;
                    3'b111:  dec.alu_op = 5'd13;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec.mem_to_reg   = 1'b1;
                dec.reg_write    = 1'b1;
                dec.alu_from_imm = 1'b1;
                case (f3)
                    3'b000:  dec.inst_type = 4'd8;
                    3'b001:  dec.inst_type = 4'd9;
                    3'b010:  dec.inst_type = 4'd10;
                    3'b100:  dec.inst_type = 4'd11;
                    3'b101:  dec.inst_type = 4'd15;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                dec.alu_from_imm = 1'b1;
                case (f3)
                    3'b000:  dec.inst_type = 4'd12;
                    3'b001:  dec.inst_type = 4'd13;
                    3'b010:  dec.inst_type = 4'd14;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.reg_write    = 1'b1;
                dec.alu_from_imm = 1'b1;
                case (f3)
                    3'b000: dec.alu_op = 5'd0;
                    3'b010: dec.alu_op = 5'd3;
                    3'b011: dec.alu_op = 5'd4;
                    3'b100: dec.alu_op = 5'd5;
                    3'b110: dec.alu_op = 5'd8;
                    3'b111: dec.alu_op = 5'd9;
                    3'b001: begin
                        dec.alu_op = 5'd2;
                        illegal    = (f7 != 7'b0000000);
                    end
                    default: begin
                        if (f7 == 7'b0000000)      dec.alu_op = 5'd6;
                        else if (f7 == 7'b0100000) dec.alu_op = 5'd7;
                        else                       illegal    = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                dec.reg_write = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec.alu_op = 5'd0;
                        3'b001:  dec.alu_op = 5'd2;
                        3'b010:  dec.alu_op = 5'd3;
                        3'b011:  dec.alu_op = 5'd4;
                        3'b100:  dec.alu_op = 5'd5;
                        3'b101:  dec.alu_op = 5'd6;
                        3'b110:  dec.alu_op = 5'd8;
                        default: dec.alu_op = 5'd9;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec.alu_op = 5'd1;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec.alu_op = 5'd7;
                end else if (f7 == 7'b0000001 && SUPPORT_M != 0) begin
                    dec.alu_op = {2'b10, f3};
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b0001111: dec.is_fence = 1'b1;
            7'b1110011: begin
                if (f3 == 3'b000) begin
                    case (bus.in_instr)
                        32'h0000_0073: begin dec.exc_request = 1'b1; dec.exc_cause = 32'd11; end
                        32'h0010_0073: begin dec.exc_request = 1'b1; dec.exc_cause = 32'd3;  end
                        32'h3020_0073: dec.is_mret = 1'b1;
                        32'h1050_0073: dec.is_wfi  = 1'b1;
                        default:       illegal     = 1'b1;
                    endcase
                end else if (f3 == 3'b100 || SUPPORT_CSR == 0) begin
                    illegal = 1'b1;
                end else begin
                    dec.reg_write  = 1'b1;
                    dec.reg_data   = 2'd2;
                    dec.csr_source = f3[2];
                    // set/clear with a zero operand is a pure read
                    dec.csr_op     = (f3[1] && rs1 == 5'd0) ? 2'd0 : f3[1:0];
                end
            end
            default: illegal = 1'b1;
        endcase

        if (rd == 5'd0) dec.reg_write = 1'b0;

        if (illegal) begin
            dec             = '0;
            dec.exc_request = 1'b1;
            dec.exc_cause   = 32'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_RUN;
            run_en               <= 1'b0;
            bus.out_valid        <= 1'b0;
            bus.out_pc           <= '0;
            bus.out_instr        <= '0;
            bus.out_is_branch    <= 1'b0;
            bus.out_is_jump      <= 1'b0;
            bus.out_mem_to_reg   <= 1'b0;
            bus.out_alu_from_imm <= 1'b0;
            bus.out_alu_from_pc  <= 1'b0;
            bus.out_reg_write    <= 1'b0;
            bus.out_csr_source   <= 1'b0;
            bus.out_is_mret      <= 1'b0;
            bus.out_reg_data     <= '0;
            bus.out_inst_type    <= '0;
            bus.out_alu_op       <= '0;
            bus.out_csr_op       <= '0;
            bus.out_exc_request  <= 1'b0;
            bus.out_exc_cause    <= '0;
        end else begin
            run_en <= 1'b1;
            if (flush) begin
                state         <= ST_RUN;
                bus.out_valid <= 1'b0;
            end else begin
                if (accept) begin
                    bus.out_valid        <= 1'b1;
                    bus.out_pc           <= bus.in_pc[XLEN-1:0];
                    bus.out_instr        <= bus.in_instr;
                    bus.out_is_branch    <= dec.is_branch;
                    bus.out_is_jump      <= dec.is_jump;
                    bus.out_mem_to_reg   <= dec.mem_to_reg;
                    bus.out_alu_from_imm <= dec.alu_from_imm;
                    bus.out_alu_from_pc  <= dec.alu_from_pc;
                    bus.out_reg_write    <= dec.reg_write;
                    bus.out_csr_source   <= dec.csr_source;
                    bus.out_is_mret      <= dec.is_mret;
                    bus.out_reg_data     <= dec.reg_data;
                    bus.out_inst_type    <= dec.inst_type;
                    bus.out_alu_op       <= dec.alu_op;
                    bus.out_csr_op       <= dec.csr_op;
                    bus.out_exc_request  <= dec.exc_request;
                    bus.out_exc_cause    <= dec.exc_cause;
                end else if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                end

                case (state)
                    ST_RUN: begin
                        if (accept && dec.is_wfi)        state <= ST_WFI;
                        else if (accept && dec.is_fence) state <= ST_DRAIN;
                    end
                    ST_WFI:   if (irq_pending) state <= ST_RUN;
                    ST_DRAIN: if (lsu_idle)    state <= ST_RUN;
                    default:  state <= ST_RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: one instance with M+CSR, one with neither,
// both fed the same instruction stream.
module tb_decode_ctrl_stage;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        irq_pending;
    logic        lsu_idle;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;
    logic [1:0]  dbg_state_m;
    logic [1:0]  dbg_state_b;

    int checks;
    int errors;

    decode_ctrl_stage_if #(.XLEN(32)) bus_m ();
    decode_ctrl_stage_if #(.XLEN(32)) bus_b ();

    assign bus_m.in_valid  = in_valid;
    assign bus_m.in_instr  = in_instr;
    assign bus_m.in_pc     = in_pc;
    assign bus_m.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_instr  = in_instr;
    assign bus_b.in_pc     = in_pc;
    assign bus_b.out_ready = out_ready;

    decode_ctrl_stage #(.XLEN(32), .SUPPORT_M(1), .SUPPORT_CSR(1)) dut_m (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .irq_pending (irq_pending),
        .lsu_idle    (lsu_idle),
        .bus         (bus_m),
        .dbg_state   (dbg_state_m)
    );

    decode_ctrl_stage #(.XLEN(32), .SUPPORT_M(0), .SUPPORT_CSR(0)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .irq_pending (irq_pending),
        .lsu_idle    (lsu_idle),
        .bus         (bus_b),
        .dbg_state   (dbg_state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        flush       = 1'b0;
        irq_pending = 1'b0;
        lsu_idle    = 1'b1;
        in_valid    = 1'b0;
        in_instr    = 32'h0;
        in_pc       = 32'h0;
        out_ready   = 1'b1;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus_m.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus_m.out_valid), 32'd0);
        chk("rst_exc", 32'(bus_m.out_exc_request), 32'd0);
        chk("rst_state", 32'(dbg_state_m), 32'd0);
        chk("rst_out_pc", bus_m.out_pc, 32'd0);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_before_clk", 32'(bus_m.in_ready), 32'd0);
        tick();
        chk("rel_in_ready_after_clk", 32'(bus_m.in_ready), 32'd1);

        // addi x1,x0,5
        send(32'h0050_0093, 32'h100);
        chk("addi_valid", 32'(bus_m.out_valid), 32'd1);
        chk("addi_alu_op", 32'(bus_m.out_alu_op), 32'd0);
        chk("addi_imm", 32'(bus_m.out_alu_from_imm), 32'd1);
        chk("addi_rw", 32'(bus_m.out_reg_write), 32'd1);
        chk("addi_exc", 32'(bus_m.out_exc_request), 32'd0);
        chk("addi_pc", bus_m.out_pc, 32'h100);
        chk("addi_instr", bus_m.out_instr, 32'h0050_0093);
        tick();
        chk("drain_valid", 32'(bus_m.out_valid), 32'd0);

        // exceptions and assorted decodes, back to back
        send(32'h0000_0000, 32'h104);
        chk("ill0_exc", 32'(bus_m.out_exc_request), 32'd1);
        chk("ill0_cause", bus_m.out_exc_cause, 32'd2);
        chk("ill0_rw", 32'(bus_m.out_reg_write), 32'd0);
        send(32'h0000_0073, 32'h108);
        chk("ecall_cause", bus_m.out_exc_cause, 32'd11);
        chk("ecall_rw", 32'(bus_m.out_reg_write), 32'd0);
        send(32'h0010_0073, 32'h10c);
        chk("ebreak_cause", bus_m.out_exc_cause, 32'd3);
        chk("ebreak_exc", 32'(bus_m.out_exc_request), 32'd1);
        send(32'h0050_0090, 32'h110);
        chk("lowbits_cause", bus_m.out_exc_cause, 32'd2);
        send(32'h4020_81b3, 32'h114);
        chk("sub_alu_op", 32'(bus_m.out_alu_op), 32'd1);
        chk("sub_exc", 32'(bus_m.out_exc_request), 32'd0);
        send(32'h0000_a283, 32'h118);
        chk("lw_type", 32'(bus_m.out_inst_type), 32'd10);
        chk("lw_m2r", 32'(bus_m.out_mem_to_reg), 32'd1);
        send(32'h0020_8463, 32'h11c);
        chk("beq_branch", 32'(bus_m.out_is_branch), 32'd1);
        chk("beq_alu_op", 32'(bus_m.out_alu_op), 32'd10);
        chk("beq_rw", 32'(bus_m.out_reg_write), 32'd0);
        send(32'h0000_00ef, 32'h120);
        chk("jal_jump", 32'(bus_m.out_is_jump), 32'd1);
        chk("jal_reg_data", 32'(bus_m.out_reg_data), 32'd1);
        chk("jal_rw", 32'(bus_m.out_reg_write), 32'd1);
        send(32'h6010_5093, 32'h124);
        chk("srai_bad_f7_cause", bus_m.out_exc_cause, 32'd2);
        chk("srai_bad_f7_type", 32'(bus_m.out_inst_type), 32'd0);
        send(32'h3020_0073, 32'h128);
        chk("mret_flag", 32'(bus_m.out_is_mret), 32'd1);
        chk("mret_exc", 32'(bus_m.out_exc_request), 32'd0);
        tick();

        // backpressure: first word held, second follows with no bubble
        out_ready = 1'b0;
        send(32'h0050_0093, 32'h200);
        in_valid = 1'b1;
        in_instr = 32'h00a0_0113;
        in_pc    = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(bus_m.in_ready), 32'd0);
            chk("bp_hold_pc", bus_m.out_pc, 32'h200);
            chk("bp_hold_valid", 32'(bus_m.out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(bus_m.in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_pc", bus_m.out_pc, 32'h204);
        chk("bp_second_instr", bus_m.out_instr, 32'h00a0_0113);
        chk("bp_second_valid", 32'(bus_m.out_valid), 32'd1);
        tick();
        chk("bp_drained", 32'(bus_m.out_valid), 32'd0);

        // WFI sleep
        send(32'h1050_0073, 32'h300);
        chk("wfi_valid", 32'(bus_m.out_valid), 32'd1);
        chk("wfi_rw", 32'(bus_m.out_reg_write), 32'd0);
        chk("wfi_state", 32'(dbg_state_m), 32'd1);
        in_valid = 1'b1;
        in_instr = 32'h0050_0093;
        in_pc    = 32'h304;
        for (int i = 0; i < 5; i++) begin
            #1 chk("wfi_stall", 32'(bus_m.in_ready), 32'd0);
            tick();
        end
        irq_pending = 1'b1;
        #1 chk("wfi_irq_cycle", 32'(bus_m.in_ready), 32'd0);
        tick();
        irq_pending = 1'b0;
        #1 chk("wfi_wake_ready", 32'(bus_m.in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("wfi_next_pc", bus_m.out_pc, 32'h304);
        chk("wfi_next_valid", 32'(bus_m.out_valid), 32'd1);
        tick();

        // FENCE drain
        lsu_idle = 1'b0;
        send(32'h0ff0_000f, 32'h400);
        chk("fence_state", 32'(dbg_state_m), 32'd2);
        chk("fence_rw", 32'(bus_m.out_reg_write), 32'd0);
        in_valid = 1'b1;
        in_instr = 32'h0050_0093;
        in_pc    = 32'h404;
        for (int i = 0; i < 4; i++) begin
            #1 chk("fence_stall", 32'(bus_m.in_ready), 32'd0);
            tick();
        end
        lsu_idle = 1'b1;
        #1 chk("fence_idle_cycle", 32'(bus_m.in_ready), 32'd0);
        tick();
        #1 chk("fence_done_ready", 32'(bus_m.in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("fence_next_pc", bus_m.out_pc, 32'h404);
        tick();

        // flush in the middle of DRAIN
        lsu_idle = 1'b0;
        send(32'h0ff0_000f, 32'h500);
        out_ready = 1'b0;
        tick();
        chk("flush_pre_state", 32'(dbg_state_m), 32'd2);
        chk("flush_pre_valid", 32'(bus_m.out_valid), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0050_0093;
        in_pc    = 32'h504;
        #1 chk("flush_in_ready", 32'(bus_m.in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(bus_m.out_valid), 32'd0);
        chk("flush_state", 32'(dbg_state_m), 32'd0);
        chk("flush_dropped_pc", bus_m.out_pc, 32'h500);
        #1 chk("flush_after_ready", 32'(bus_m.in_ready), 32'd1);
        lsu_idle  = 1'b1;
        out_ready = 1'b1;

        // M extension and CSR decode on both configurations
        send(32'h0220_8033, 32'h600);
        chk("mul_alu_op", 32'(bus_m.out_alu_op), 32'd16);
        chk("mul_rw_x0", 32'(bus_m.out_reg_write), 32'd0);
        chk("mul_exc", 32'(bus_m.out_exc_request), 32'd0);
        chk("mul_nom_exc", 32'(bus_b.out_exc_request), 32'd1);
        chk("mul_nom_cause", bus_b.out_exc_cause, 32'd2);
        send(32'h3000_22f3, 32'h604);
        chk("csrrs0_op", 32'(bus_m.out_csr_op), 32'd0);
        chk("csrrs0_reg_data", 32'(bus_m.out_reg_data), 32'd2);
        chk("csrrs0_rw", 32'(bus_m.out_reg_write), 32'd1);
        chk("csrrs0_exc", 32'(bus_m.out_exc_request), 32'd0);
        chk("csr_nocsr_cause", bus_b.out_exc_cause, 32'd2);
        chk("csr_nocsr_rw", 32'(bus_b.out_reg_write), 32'd0);
        send(32'h3000_a2f3, 32'h608);
        chk("csrrs1_op", 32'(bus_m.out_csr_op), 32'd2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
